// File: rtl/miner_util_pkg.sv
// Shared helpers for the miner datapath: beat counting, config checks and byte reversal.
// Byte reversal is width-generic: callers zero-extend into BSWAP_MAX_W and truncate the result.
package miner_util_pkg;

  localparam int unsigned BSWAP_MAX_W = 1024;

  function automatic int unsigned calc_beats(input int unsigned size, input int unsigned in_w);
    return size / in_w;
  endfunction

  function automatic bit cfg_ok(input int unsigned size, input int unsigned in_w);
    return (in_w != 0) && (in_w % 8 == 0) && (size % in_w == 0) && (size % 8 == 0)
           && (size <= BSWAP_MAX_W) && (size >= in_w);
  endfunction

  // Reverses the low width/8 bytes of d; byte 0 swaps with byte width/8-1.
  function automatic logic [BSWAP_MAX_W-1:0] bswap(input logic [BSWAP_MAX_W-1:0] d,
                                                  input int unsigned width);
    logic [BSWAP_MAX_W-1:0] r;
    int unsigned nb;
    r  = '0;
    nb = width / 8;
    for (int unsigned i = 0; i < BSWAP_MAX_W / 8; i++) begin
      if (i < nb) r[i*8 +: 8] = d[(nb-1-i)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/beat_accumulator.sv
// Beat counter and word accumulator; exposes the merged word and its swap flag on the completing beat.
// Zero-clear on completion guarantees unwritten beat positions of a short word read as zero.
module beat_accumulator
  import miner_util_pkg::*;
#(
  parameter int unsigned SIZE = 128,
  parameter int unsigned IN_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            beat_vld_i,
  input  logic [IN_W-1:0] beat_dat_i,
  input  logic            beat_last_i,
  input  logic            swap_en_i,
  output logic            cnt_last_o,
  output logic            done_o,
  output logic            swap_o,
  output logic [SIZE-1:0] word_o
);

  localparam int unsigned BEATS = calc_beats(SIZE, IN_W);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]  acc_q, acc_d;
  logic             swap_q, swap_d;

  assign cnt_last_o = (cnt_q == CNT_MAX);
  assign done_o     = beat_vld_i && (cnt_last_o || beat_last_i);
  // Beat 0 has not latched yet, so a one-beat word takes its flag straight from the input.
  assign swap_o     = (cnt_q == '0) ? swap_en_i : swap_q;

  always_comb begin
    word_o = acc_q;
    word_o[cnt_q*IN_W +: IN_W] = beat_dat_i;
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    swap_d = swap_q;
    if (beat_vld_i) begin
      if (cnt_q == '0) swap_d = swap_en_i;
      if (done_o) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = word_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      swap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      swap_q <= swap_d;
    end
  end

endmodule

// File: rtl/bswap_stream_packer.sv
// Packs IN_W-bit host beats into SIZE-bit words with optional byte reversal; one-word output register.
// s_ready drops only when the incoming beat could complete a word while the output is stalled.
module bswap_stream_packer
  import miner_util_pkg::*;
#(
  parameter int unsigned SIZE = 128,
  parameter int unsigned IN_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            swap_en,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [IN_W-1:0] s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [SIZE-1:0] m_data,
  output logic            m_last
);

  if (!cfg_ok(SIZE, IN_W)) begin : g_cfg_err
    $error("bswap_stream_packer: SIZE must be a multiple of IN_W and 8, IN_W a multiple of 8");
  end

  logic            xfer, cnt_last, done, swap;
  logic [SIZE-1:0] word, load_dat;
  logic            m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [SIZE-1:0] m_data_q, m_data_d;

  assign s_ready = !m_valid_q || m_ready || (!cnt_last && !s_last);
  assign xfer    = s_valid && s_ready;

  beat_accumulator #(.SIZE(SIZE), .IN_W(IN_W)) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .beat_vld_i  (xfer),
    .beat_dat_i  (s_data),
    .beat_last_i (s_last),
    .swap_en_i   (swap_en),
    .cnt_last_o  (cnt_last),
    .done_o      (done),
    .swap_o      (swap),
    .word_o      (word)
  );

  assign load_dat = swap ? SIZE'(bswap(BSWAP_MAX_W'(word), SIZE)) : word;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (done) begin
      m_valid_d = 1'b1;
      m_data_d  = load_dat;
      m_last_d  = s_last;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_bswap_stream_packer.sv
// Directed bench for bswap_stream_packer (SIZE=128, IN_W=32) with an output scoreboard.
module tb_bswap_stream_packer;

  logic         clk = 1'b0;
  logic         rst_n, swap_en, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [31:0]  s_data;
  logic [127:0] m_data;

  int tests = 0;
  int fails = 0;
  logic [128:0] exp_q[$];

  always #5 clk = ~clk;

  bswap_stream_packer #(.SIZE(128), .IN_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .swap_en(swap_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every word leaving the output register must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_word observed=%h expected=none", {m_last, m_data});
      end else begin
        check("out_word", {m_last, m_data}, exp_q.pop_front());
      end
    end
  end

  task automatic beat(input logic [31:0] d, input logic l, input logic sw);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    swap_en = sw;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("beat_accept", 129'(ok), 129'(1));
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && (exp_q.size() != 0 || m_valid); n++) begin
      @(posedge clk);
      #1;
    end
    check("drained", 129'(exp_q.size()), 129'(0));
  endtask

  logic [31:0]  bp [8];
  logic [127:0] w1, w2;

  initial begin
    rst_n = 1'b0; swap_en = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 129'(m_valid), 129'(0));
    check("rst_m_data",  129'(m_data),  129'(0));
    check("rst_m_last",  129'(m_last),  129'(0));
    check("rst_s_ready", 129'(s_ready), 129'(1));
    rst_n = 1'b1;

    // Full word, no swap; output must be valid right after the completing beat's edge.
    exp_q.push_back({1'b0, 128'hCCDDEEFF_8899AABB_44556677_00112233});
    beat(32'h00112233, 1'b0, 1'b0);
    beat(32'h44556677, 1'b0, 1'b0);
    beat(32'h8899AABB, 1'b0, 1'b0);
    check("pre_done_m_valid", 129'(m_valid), 129'(0));
    beat(32'hCCDDEEFF, 1'b0, 1'b0);
    check("latency_m_valid", 129'(m_valid), 129'(1));
    drain();

    // Full word with swap requested only on beat 0.
    exp_q.push_back({1'b0, 128'h33221100_77665544_BBAA9988_FFEEDDCC});
    beat(32'h00112233, 1'b0, 1'b1);
    beat(32'h44556677, 1'b0, 1'b0);
    beat(32'h8899AABB, 1'b0, 1'b0);
    beat(32'hCCDDEEFF, 1'b0, 1'b0);
    drain();

    // Early close, without and with swap.
    exp_q.push_back({1'b1, 128'h00000000_00000000_44556677_00112233});
    beat(32'h00112233, 1'b0, 1'b0);
    beat(32'h44556677, 1'b1, 1'b0);
    exp_q.push_back({1'b1, 128'h33221100_77665544_00000000_00000000});
    beat(32'h00112233, 1'b0, 1'b1);
    beat(32'h44556677, 1'b1, 1'b1);
    drain();

    // s_last on beat 0 gives a one-beat word, swapped.
    exp_q.push_back({1'b1, 128'hDDCCBBAA_00000000_00000000_00000000});
    beat(32'hAABBCCDD, 1'b1, 1'b1);
    drain();

    // Backpressure: 7 beats absorbed, the 8th stalls until m_ready returns.
    for (int i = 0; i < 8; i++) bp[i] = 32'h10203040 + 32'(i) * 32'h01010101;
    w1 = {bp[3], bp[2], bp[1], bp[0]};
    w2 = {bp[7], bp[6], bp[5], bp[4]};
    m_ready = 1'b0;
    exp_q.push_back({1'b0, w1});
    exp_q.push_back({1'b0, w2});
    for (int i = 0; i < 7; i++) beat(bp[i], 1'b0, 1'b0);
    s_valid = 1'b1; s_data = bp[7]; s_last = 1'b0; swap_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_s_ready_low", 129'(s_ready), 129'(0));
      check("bp_hold_data", {m_valid, m_data}, {1'b1, w1});
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_s_ready_release", 129'(s_ready), 129'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("reload_word", {m_valid, m_data}, {1'b1, w2});
    drain();

    // Reset mid-word discards the partial word.
    beat(32'hDEADBEEF, 1'b0, 1'b1);
    beat(32'hCAFEF00D, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_outputs", {m_valid, m_last, m_data}, 130'(0));
    check("midrst_s_ready", 129'(s_ready), 129'(1));
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 128'h44444444_33333333_22222222_11111111});
    beat(32'h11111111, 1'b0, 1'b0);
    beat(32'h22222222, 1'b0, 1'b0);
    beat(32'h33333333, 1'b0, 1'b0);
    beat(32'h44444444, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
